// File: rtl/vga_seq_pkg.sv
// Shared constants and FSM state type for the per-frame job sequencer.
package vga_seq_pkg;

  localparam int H_ACTIVE = 640;
  localparam int Y_ACTIVE = 480;
  localparam int FRAME_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

endpackage

// File: rtl/vga_vblank_sequencer_if.sv
// Job offer channel from the sequencer to the effect engine.
interface vga_vblank_sequencer_if
  import vga_seq_pkg::*;
#(
  parameter int JOB_W = 2
) ();

  // Handshake: a job transfers on any cycle where job_valid && job_ready. Once
  // job_valid is high, job_id/job_frame hold until that transfer; the only
  // withdrawal without a transfer is an abort when active video returns.
  logic               job_valid;
  logic [JOB_W-1:0]   job_id;
  logic [FRAME_W-1:0] job_frame;
  logic               job_ready;

  modport master (output job_valid, output job_id, output job_frame, input job_ready);
  modport slave  (input job_valid, input job_id, input job_frame, output job_ready);

endinterface

// File: rtl/vga_vblank_sequencer_detect.sv
// Vertical-blank start detector: one-cycle strobe on the first pixel of line Y_LINE.
module vga_vblank_detect #(
  parameter int Y_LINE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  output logic       vb_start
);

  logic vb_cond;
  logic vb_cond_q;

  assign vb_cond = (y_px == 10'(Y_LINE)) && (x_px == 10'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_cond_q <= 1'b0;
    end else begin
      vb_cond_q <= vb_cond;
    end
  end

  // Rising edge only, so a coordinate held for several clocks counts once.
  assign vb_start = vb_cond && !vb_cond_q;

endmodule

// File: rtl/vga_vblank_sequencer.sv
// Per-frame update scheduler: counts frames and issues NUM_JOBS ordered jobs per vblank.
// Optional build macro FRAME_DIV_EN: start a sequence only every 2**DIV_LOG2 frames.
module vga_vblank_sequencer
  import vga_seq_pkg::*;
#(
  parameter int NUM_JOBS = 4,
  parameter int JOB_W    = 2,
  parameter int Y_ACTIVE = vga_seq_pkg::Y_ACTIVE,
  parameter int DIV_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   pause,
  input  logic [9:0]             x_px,
  input  logic [9:0]             y_px,
  input  logic                   activevideo,
  vga_vblank_sequencer_if.master job,
  output logic [FRAME_W-1:0]     frame_cnt,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output seq_state_t             state_dbg
);

`ifdef FRAME_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [JOB_W-1:0] LAST_IDX = JOB_W'(NUM_JOBS - 1);

  seq_state_t         state, state_n;
  logic [JOB_W-1:0]   idx, idx_n;
  logic [FRAME_W-1:0] frame_cnt_r, frame_cnt_n, frame_inc;
  logic [FRAME_W-1:0] job_frame_r, job_frame_n;
  logic               overrun_r, overrun_n;
  logic               vb_start, start_ok, div_ok, hs, last_job;

  vga_vblank_detect #(.Y_LINE(Y_ACTIVE)) u_detect (
    .clk      (clk),
    .rst      (rst),
    .x_px     (x_px),
    .y_px     (y_px),
    .vb_start (vb_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      frame_cnt_r <= '0;
      job_frame_r <= '0;
      overrun_r   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      frame_cnt_r <= frame_cnt_n;
      job_frame_r <= job_frame_n;
      overrun_r   <= overrun_n;
    end
  end

  always_comb begin
    frame_inc   = frame_cnt_r + FRAME_W'(1);
    start_ok    = vb_start && ena && !pause;
    div_ok      = !DIV_EN || (frame_inc[DIV_LOG2-1:0] == '0);
    hs          = (state == ISSUE) && job.job_ready;
    last_job    = (idx == LAST_IDX);
    state_n     = state;
    idx_n       = idx;
    frame_cnt_n = frame_cnt_r;
    job_frame_n = job_frame_r;
    // Set conditions below override the clear.
    overrun_n   = overrun_clr ? 1'b0 : overrun_r;

    case (state)
      IDLE: begin
        if (start_ok) begin
          frame_cnt_n = frame_inc;
          if (div_ok) begin
            state_n     = ISSUE;
            idx_n       = '0;
            job_frame_n = frame_inc;
          end
        end
      end
      ISSUE: begin
        // A new frame arriving mid-sequence is counted but does not restart it.
        if (start_ok) begin
          frame_cnt_n = frame_inc;
          overrun_n   = 1'b1;
        end
        if (activevideo) begin
          state_n   = IDLE;
          idx_n     = '0;
          overrun_n = 1'b1;
        end else if (hs) begin
          if (last_job) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + JOB_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign job.job_valid = (state == ISSUE);
  assign job.job_id    = idx;
  assign job.job_frame = job_frame_r;
  assign frame_cnt     = frame_cnt_r;
  assign busy          = (state == ISSUE);
  assign overrun       = overrun_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_vga_vblank_sequencer.sv
// Directed bench for vga_vblank_sequencer: job scoreboard plus direct output checks.
module tb_vga_vblank_sequencer;
  import vga_seq_pkg::*;

  localparam int NUM_JOBS = 4;
  localparam int JOB_W    = 2;
  localparam int SB_W     = JOB_W + FRAME_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         pause;
  logic [9:0]   x_px;
  logic [9:0]   y_px;
  logic         activevideo;
  logic         overrun_clr;
  logic [15:0]  frame_cnt;
  logic         busy;
  logic         overrun;
  seq_state_t   state_dbg;

  vga_vblank_sequencer_if #(.JOB_W(JOB_W)) job_if ();

  vga_vblank_sequencer #(
    .NUM_JOBS (NUM_JOBS),
    .JOB_W    (JOB_W),
    .Y_ACTIVE (480),
    .DIV_LOG2 (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .pause       (pause),
    .x_px        (x_px),
    .y_px        (y_px),
    .activevideo (activevideo),
    .job         (job_if.master),
    .frame_cnt   (frame_cnt),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] exp_item;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && job_if.job_valid && job_if.job_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL job_unexpected actual id=%0d frame=%0h required=no job",
                 job_if.job_id, job_if.job_frame);
      end else begin
        exp_item = exp_q.pop_front();
        if ({job_if.job_id, job_if.job_frame} !== exp_item) begin
          failures++;
          $display("FAIL job_order actual id=%0d frame=%0h required id=%0d frame=%0h",
                   job_if.job_id, job_if.job_frame,
                   exp_item[SB_W-1 -: JOB_W], exp_item[FRAME_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pixel position sits on line 480 column 0 for one clock, then moves away.
  task automatic vblank();
    y_px = 10'd480;
    x_px = 10'd0;
    step();
    y_px = 10'd100;
    x_px = 10'd1;
    step();
  endtask

  task automatic push_frame(input logic [15:0] f);
    for (int i = 0; i < NUM_JOBS; i++) exp_q.push_back({JOB_W'(i), f});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    check(name, 32'(busy), 32'(0));
  endtask

  task automatic reset_mid_issue();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid",   32'(job_if.job_valid), 32'(0));
    check("rst_mid_busy",    32'(busy),             32'(0));
    check("rst_mid_frame",   32'(frame_cnt),        32'(0));
    check("rst_mid_jframe",  32'(job_if.job_frame), 32'(0));
    check("rst_mid_jid",     32'(job_if.job_id),    32'(0));
    check("rst_mid_overrun", 32'(overrun),          32'(0));
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    ena = 1'b1;
    pause = 1'b0;
    activevideo = 1'b0;
    overrun_clr = 1'b0;
    x_px = 10'd1;
    y_px = 10'd100;
    job_if.job_ready = 1'b0;
    repeat (3) step();
    check("rst_valid",   32'(job_if.job_valid), 32'(0));
    check("rst_busy",    32'(busy),             32'(0));
    check("rst_frame",   32'(frame_cnt),        32'(0));
    check("rst_overrun", 32'(overrun),          32'(0));
    check("rst_jid",     32'(job_if.job_id),    32'(0));
    check("rst_jframe",  32'(job_if.job_frame), 32'(0));
    check("rst_state",   32'(state_dbg),        32'(IDLE));
    rst = 1'b0;
    step();

`ifdef FRAME_DIV_EN
    // Only frames 4 and 8 start a sequence; the counter still advances every frame.
    job_if.job_ready = 1'b1;
    for (int f = 1; f <= 8; f++) begin
      if (f % 4 == 0) push_frame(16'(f));
      vblank();
      wait_idle("div_idle");
    end
    check("div_frame8",  32'(frame_cnt), 32'(8));
    check("div_overrun", 32'(overrun),   32'(0));
    job_if.job_ready = 1'b0;
    repeat (3) vblank();
    check("div_skip_busy",  32'(busy),      32'(0));
    check("div_skip_frame", 32'(frame_cnt), 32'(11));
    vblank();
    check("div_start_busy",  32'(busy),             32'(1));
    check("div_start_jframe", 32'(job_if.job_frame), 32'(12));
    reset_mid_issue();
`else
    // Normal frame, ready held high: four back-to-back jobs for frame 1.
    job_if.job_ready = 1'b1;
    push_frame(16'd1);
    vblank();
    check("normal_frame",  32'(frame_cnt),        32'(1));
    check("normal_busy",   32'(busy),             32'(1));
    check("normal_jframe", 32'(job_if.job_frame), 32'(1));
    check("normal_id_mid", 32'(job_if.job_id),    32'(1));
    repeat (2) step();
    check("normal_busy_last", 32'(busy), 32'(1));
    step();
    check("normal_busy_drop", 32'(busy), 32'(0));

    // Backpressure on job 1 for five cycles.
    push_frame(16'd2);
    vblank();
    job_if.job_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_hold", 32'(job_if.job_valid), 32'(1));
      check("bp_id_hold",    32'(job_if.job_id),    32'(1));
    end
    check("bp_jframe", 32'(job_if.job_frame), 32'(2));
    job_if.job_ready = 1'b1;
    step();
    check("bp_next_id", 32'(job_if.job_id), 32'(2));
    wait_idle("bp_idle");

    // Abort by active video with the engine stalled.
    job_if.job_ready = 1'b0;
    vblank();
    check("abort_pre_busy", 32'(busy), 32'(1));
    activevideo = 1'b1;
    step();
    activevideo = 1'b0;
    check("abort_overrun", 32'(overrun),          32'(1));
    check("abort_busy",    32'(busy),             32'(0));
    check("abort_valid",   32'(job_if.job_valid), 32'(0));
    check("abort_frame",   32'(frame_cnt),        32'(3));
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'(0));
    vblank();
    activevideo = 1'b1;
    overrun_clr = 1'b1;
    step();
    activevideo = 1'b0;
    overrun_clr = 1'b0;
    check("clr_vs_set", 32'(overrun), 32'(1));
    step();
    check("overrun_sticky", 32'(overrun), 32'(1));
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("clr_again", 32'(overrun), 32'(0));

    // Late sequence: a second vblank arrives while frame 5 jobs are pending.
    push_frame(16'd5);
    vblank();
    vblank();
    check("late_frame",   32'(frame_cnt),        32'(6));
    check("late_overrun", 32'(overrun),          32'(1));
    check("late_busy",    32'(busy),             32'(1));
    check("late_jframe",  32'(job_if.job_frame), 32'(5));
    check("late_jid",     32'(job_if.job_id),    32'(0));
    job_if.job_ready = 1'b1;
    wait_idle("late_idle");
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;

    // Pause and disable both block new frames.
    pause = 1'b1;
    repeat (3) vblank();
    check("pause_frame", 32'(frame_cnt), 32'(6));
    check("pause_busy",  32'(busy),      32'(0));
    pause = 1'b0;
    ena = 1'b0;
    vblank();
    check("ena_frame", 32'(frame_cnt), 32'(6));
    check("ena_busy",  32'(busy),      32'(0));
    ena = 1'b1;

    // Counter wrap: preset to 0xFFFF, next frame carries job_frame 0.
    force dut.frame_cnt_r = 16'hFFFF;
    step();
    release dut.frame_cnt_r;
    #1;
    check("wrap_preset", 32'(frame_cnt), 32'h0000_FFFF);
    push_frame(16'd0);
    vblank();
    check("wrap_frame",  32'(frame_cnt),        32'(0));
    check("wrap_jframe", 32'(job_if.job_frame), 32'(0));
    wait_idle("wrap_idle");

    // Asynchronous reset in the middle of a stalled, overrun sequence.
    job_if.job_ready = 1'b0;
    vblank();
    vblank();
    check("pre_rst_busy",    32'(busy),    32'(1));
    check("pre_rst_overrun", 32'(overrun), 32'(1));
    reset_mid_issue();
`endif

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
